pc_sequencer: RTL and testbench

Fetch sequencer that owns the program counter register for the MIPS datapath. It issues instruction-fetch requests to instruction memory and waits for the memory acknowledge. Once an instruction is presented to decode, it selects the next PC from four sources: sequential, branch, jump or exception vector. It also captures the EPC on exceptions.

---
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_sequencer.sv | 89 ++++++++
 tb/tb_pc_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_sequencer_if : fetch/issue/redirect bundle for the PC sequencer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface pc_sequencer_if;
  logic        fetchReq;
  logic [31:0] fetchAddr;
  logic        fetchAck;
  logic        instrValid;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        exception;
  logic [31:0] pcOut;
  logic [31:0] epc;

  modport master (
    output fetchReq, fetchAddr, instrValid, pcOut, epc,
    input  fetchAck, stall, branchTaken, branchTarget, jump, jumpTarget, exception
  );

  modport slave (
    input  fetchReq, fetchAddr, instrValid, pcOut, epc,
    output fetchAck, stall, branchTaken, branchTarget, jump, jumpTarget, exception
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pc_sequencer : owns the PC, sequences fetch/issue, captures EPC    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
  input  wire logic           clk,
  input  wire logic           reset,
  pc_sequencer_if.master      bus
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_epc;
  logic        r_fetchReq;
  logic        r_instrValid;

  logic        w_redirect;
  logic [31:0] w_target;
  logic        w_addrErr;

  // Jump outranks branch, so the target checked for alignment is the jump's when both fire.
  always_comb begin
    w_redirect = bus.jump | bus.branchTaken;
    w_target   = bus.jump ? bus.jumpTarget : bus.branchTarget;
    w_addrErr  = w_redirect & (|w_target[1:0]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_epc        <= 32'h0000_0000;
      r_fetchReq   <= 1'b0;
      r_instrValid <= 1'b0;
    end else begin
      case (r_state)
        BOOT: begin
          r_state    <= FETCH;
          r_fetchReq <= 1'b1;
        end
        FETCH: begin
          if (bus.fetchAck) begin
            r_state      <= ISSUE;
            r_fetchReq   <= 1'b0;
            r_instrValid <= 1'b1;
          end
        end
        ISSUE: begin
          // Stall blocks redirects but not a raised exception.
          if (bus.exception || (!bus.stall && w_addrErr)) begin
            r_epc        <= r_pc;
            r_pc         <= EXC_VECTOR;
            r_state      <= FETCH;
            r_fetchReq   <= 1'b1;
            r_instrValid <= 1'b0;
          end else if (!bus.stall) begin
            r_pc         <= w_redirect ? w_target : r_pc + 32'd4;
            r_state      <= FETCH;
            r_fetchReq   <= 1'b1;
            r_instrValid <= 1'b0;
          end
        end
        default: begin
          r_state      <= BOOT;
          r_fetchReq   <= 1'b0;
          r_instrValid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fetchReq   = r_fetchReq;
  assign bus.fetchAddr  = r_pc;
  assign bus.instrValid = r_instrValid;
  assign bus.pcOut      = r_pc;
  assign bus.epc        = r_epc;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pc_sequencer : vector table + scoreboard bench for pc_sequencer |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_pc_sequencer;

  logic clk;
  logic reset;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'h8000_0180)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic        stall;
    logic        br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        exc;
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] epc;
  } vec_t;

  typedef struct {
    logic        req;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] epc;
  } exp_t;

  localparam int c_NVEC = 30;
  localparam logic [31:0] c_EXC = 32'h8000_0180;

  vec_t tbl [c_NVEC];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic ack, input logic stall, input logic br,
                             input logic [31:0] bt, input logic jmp, input logic [31:0] jt,
                             input logic exc, input logic req, input logic valid,
                             input logic [31:0] pc, input logic [31:0] epc);
    vec_t r;
    r.ack = ack; r.stall = stall; r.br = br; r.bt = bt; r.jmp = jmp; r.jt = jt;
    r.exc = exc; r.req = req; r.valid = valid; r.pc = pc; r.epc = epc;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check({tag, ".fetchReq"},   {31'd0, bus.fetchReq},   {31'd0, e.req});
      check({tag, ".instrValid"}, {31'd0, bus.instrValid}, {31'd0, e.valid});
      check({tag, ".pcOut"},      bus.pcOut,               e.pc);
      check({tag, ".fetchAddr"},  bus.fetchAddr,           e.pc);
      check({tag, ".epc"},        bus.epc,                 e.epc);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.fetchAck     = t.ack;
    bus.stall        = t.stall;
    bus.branchTaken  = t.br;
    bus.branchTarget = t.bt;
    bus.jump         = t.jmp;
    bus.jumpTarget   = t.jt;
    bus.exception    = t.exc;
  endtask

  task automatic apply(input vec_t t, input string tag);
    drive(t);
    sb.push_back('{req: t.req, valid: t.valid, pc: t.pc, epc: t.epc});
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            ack st br bt            jmp jt            exc req val pc             epc
    tbl[0]  = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h0000_0000, 32'h0);
    tbl[1]  = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0000, 32'h0);
    tbl[2]  = v(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h0000_0004, 32'h0);
    tbl[3]  = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0004, 32'h0);
    tbl[4]  = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h0000_0008, 32'h0);
    tbl[5]  = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0008, 32'h0);
    // jump and branch together: jump wins
    tbl[6]  = v(0, 0, 1, 32'h200,       1, 32'h100,       0,  1, 0, 32'h0000_0100, 32'h0);
    // FETCH without ack holds; stall/jump/exception ignored there
    tbl[7]  = v(0, 1, 0, 32'h0,         1, 32'h3,         1,  1, 0, 32'h0000_0100, 32'h0);
    tbl[8]  = v(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h0000_0100, 32'h0);
    tbl[9]  = v(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h0000_0100, 32'h0);
    tbl[10] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0100, 32'h0);
    tbl[11] = v(0, 0, 1, 32'h10,        0, 32'h0,         0,  1, 0, 32'h0000_0010, 32'h0);
    tbl[12] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0010, 32'h0);
    // stall, then exception under stall
    tbl[13] = v(0, 1, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0010, 32'h0);
    tbl[14] = v(0, 1, 0, 32'h0,         0, 32'h0,         1,  1, 0, c_EXC,         32'h10);
    tbl[15] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, c_EXC,         32'h10);
    tbl[16] = v(0, 0, 0, 32'h0,         1, 32'h20,        0,  1, 0, 32'h0000_0020, 32'h10);
    tbl[17] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0020, 32'h10);
    // misaligned branch target -> address error
    tbl[18] = v(0, 0, 1, 32'h102,       0, 32'h0,         0,  1, 0, c_EXC,         32'h20);
    tbl[19] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, c_EXC,         32'h20);
    tbl[20] = v(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0,  1, 0, 32'hFFFF_FFFC, 32'h20);
    tbl[21] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'hFFFF_FFFC, 32'h20);
    // sequential wrap
    tbl[22] = v(0, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h0000_0000, 32'h20);
    tbl[23] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h0000_0000, 32'h20);
    // misaligned jump target
    tbl[24] = v(0, 0, 0, 32'h0,         1, 32'h41,        0,  1, 0, c_EXC,         32'h0);
    tbl[25] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, c_EXC,         32'h0);
    // stall masks a misaligned jump
    tbl[26] = v(0, 1, 0, 32'h0,         1, 32'h3,         0,  0, 1, c_EXC,         32'h0);
    // ack in ISSUE ignored, sequential step
    tbl[27] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  1, 0, 32'h8000_0184, 32'h0);
    tbl[28] = v(1, 0, 0, 32'h0,         0, 32'h0,         0,  0, 1, 32'h8000_0184, 32'h0);
    // aligned jump beats misaligned branch: no error
    tbl[29] = v(0, 0, 1, 32'h201,       1, 32'h300,       0,  1, 0, 32'h0000_0300, 32'h0);

    reset = 1'b0;
    drive(v(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0));
    repeat (2) @(negedge clk);
    sb.push_back('{req: 1'b0, valid: 1'b0, pc: 32'h0, epc: 32'h0});
    compare("reset");

    reset = 1'b1;
    for (int i = 0; i < c_NVEC; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Async reset while in FETCH with ack low: outputs drop before any clock edge.
    bus.fetchAck = 1'b0;
    #1;
    check("pre_rst.fetchReq", {31'd0, bus.fetchReq}, 32'd1);
    reset = 1'b0;
    #1;
    sb.push_back('{req: 1'b0, valid: 1'b0, pc: 32'h0, epc: 32'h0});
    compare("async_rst");
    @(negedge clk);
    reset = 1'b1;
    apply(v(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h0, 32'h0), "rst_boot");
    apply(v(1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1, 32'h0, 32'h0), "rst_issue");
    apply(v(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 32'h4, 32'h0), "rst_seq");

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
